// File: rtl/count_disp_pkg.sv
// Shared types and constants for the BCD converter and 7-segment scan display.
// Glyphs are encoded {g,f,e,d,c,b,a}, active-high.
package count_disp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int BCD_DIGITS = 3;
   localparam int ITER_MAX   = 7;

   localparam logic [6:0] GLYPH_0     = 7'h3F;
   localparam logic [6:0] GLYPH_1     = 7'h06;
   localparam logic [6:0] GLYPH_2     = 7'h5B;
   localparam logic [6:0] GLYPH_3     = 7'h4F;
   localparam logic [6:0] GLYPH_4     = 7'h66;
   localparam logic [6:0] GLYPH_5     = 7'h6D;
   localparam logic [6:0] GLYPH_6     = 7'h7D;
   localparam logic [6:0] GLYPH_7     = 7'h07;
   localparam logic [6:0] GLYPH_8     = 7'h7F;
   localparam logic [6:0] GLYPH_9     = 7'h6F;
   localparam logic [6:0] GLYPH_BLANK = 7'h00;

   // Decimal digit to segment pattern; non-decimal nibbles render blank.
   function automatic logic [6:0] glyph(input logic [3:0] nib);
      case (nib)
         4'd0:    return GLYPH_0;
         4'd1:    return GLYPH_1;
         4'd2:    return GLYPH_2;
         4'd3:    return GLYPH_3;
         4'd4:    return GLYPH_4;
         4'd5:    return GLYPH_5;
         4'd6:    return GLYPH_6;
         4'd7:    return GLYPH_7;
         4'd8:    return GLYPH_8;
         4'd9:    return GLYPH_9;
         default: return GLYPH_BLANK;
      endcase
   endfunction

   // Double-dabble correction step applied to one BCD nibble before each shift.
   function automatic logic [3:0] add3(input logic [3:0] nib);
      return (nib >= 4'd5) ? nib + 4'd3 : nib;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to 3-digit BCD.
// One accept in IDLE, eight shift/add-3 iterations, one DONE cycle that
// publishes the result, so a new value can be taken every 10 clocks.
//
// state | meaning
// IDLE  | in_ready high, waiting for in_valid
// SHIFT | add-3 then shift {scratch,bin}; iter 0..7
// DONE  | load bcd_out, pulse bcd_valid, return to IDLE
module bin2bcd_seq
   import count_disp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  count_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [11:0] bcd_out,
   output logic        bcd_valid
);

   state_t      state;
   logic [7:0]  bin;
   logic [11:0] scratch;
   logic [11:0] adj;
   logic [2:0]  iter;

   // Requests arriving outside IDLE are dropped, not queued.
   assign in_ready = (state == IDLE);

   // Per-nibble add-3 correction ahead of the shift.
   always_comb begin
      adj = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
   end

   // Converter FSM and shift datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bin       <= '0;
         scratch   <= '0;
         iter      <= '0;
         bcd_out   <= '0;
         bcd_valid <= 1'b0;
      end else begin
         bcd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  bin     <= count_in;
                  scratch <= '0;
                  iter    <= '0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               // Hundreds never exceeds 2, so the bit shifted out the top is always 0.
               scratch <= 12'({adj, bin[7]});
               bin     <= {bin[6:0], 1'b0};
               iter    <= iter + 3'd1;
               if (iter == 3'(ITER_MAX))
                  state <= DONE;
            end
            DONE: begin
               bcd_out   <= scratch;
               bcd_valid <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/count_bcd_display.sv
// Counter value to 3-digit multiplexed 7-segment display.
// bin2bcd_seq produces BCD; this level scans ones -> tens -> hundreds, each
// digit enabled for SCAN_DIV clocks, with seg and dig_en registered together.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros in the
// hundreds and tens positions; ones always shows its digit.
module count_bcd_display
   import count_disp_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            count_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [11:0]           bcd_out,
   output logic                  bcd_valid,
   output logic [6:0]            seg,
   output logic [BCD_DIGITS-1:0] dig_en
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [6:0] SEG_RST =
      (SEG_ACTIVE_LOW != 0) ? ~GLYPH_0 : GLYPH_0;
   localparam logic [BCD_DIGITS-1:0] DIG_RST =
      (SEG_ACTIVE_LOW != 0) ? ~BCD_DIGITS'(1) : BCD_DIGITS'(1);

   logic [CW-1:0]         scan_cnt;
   logic [1:0]            dig_idx;
   logic [3:0]            nib;
   logic [6:0]            glyph_n;
   logic [BCD_DIGITS-1:0] onehot;

   bin2bcd_seq u_conv (
      .clk       (clk),
      .rst       (rst),
      .count_in  (count_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bcd_out   (bcd_out),
      .bcd_valid (bcd_valid)
   );

   // Select the digit being scanned and build its glyph and enable.
   always_comb begin
      case (dig_idx)
         2'd1:    nib = bcd_out[7:4];
         2'd2:    nib = bcd_out[11:8];
         default: nib = bcd_out[3:0];
      endcase
      glyph_n = glyph(nib);
`ifdef LEADING_ZERO_BLANK_EN
      if (dig_idx == 2'd2 && bcd_out[11:8] == 4'd0)
         glyph_n = GLYPH_BLANK;
      if (dig_idx == 2'd1 && bcd_out[11:4] == 8'd0)
         glyph_n = GLYPH_BLANK;
`endif
      onehot = BCD_DIGITS'(1) << dig_idx;
   end

   // Scan timer and digit rotation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt <= '0;
         dig_idx  <= 2'd0;
      end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         dig_idx  <= (dig_idx == 2'd2) ? 2'd0 : dig_idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + CW'(1);
      end
   end

   // Output pin registers; polarity flip for common-anode boards happens here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg    <= SEG_RST;
         dig_en <= DIG_RST;
      end else begin
         seg    <= (SEG_ACTIVE_LOW != 0) ? ~glyph_n : glyph_n;
         dig_en <= (SEG_ACTIVE_LOW != 0) ? ~onehot : onehot;
      end
   end

endmodule

// File: tb/tb_count_bcd_display.sv
// Self-checking bench for count_bcd_display with a behavioural reference:
// conversions complete a fixed 9 edges after accept and produce decimal digits
// by division; the display index follows from the number of edges since reset.
module tb_count_bcd_display;

   localparam int SCAN_DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  count_in;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] bcd_out;
   logic        bcd_valid;
   logic [6:0]  seg;
   logic [2:0]  dig_en;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   int          m_busy;
   int          m_val;
   int          m_n;
   logic [11:0] m_bcd;
   logic [11:0] m_seg_bcd;
   logic        m_valid;

   count_bcd_display #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(0)) dut (
      .clk       (clk),
      .rst       (rst),
      .count_in  (count_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bcd_out   (bcd_out),
      .bcd_valid (bcd_valid),
      .seg       (seg),
      .dig_en    (dig_en)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [6:0] ref_glyph(input logic [3:0] d);
      case (d)
         4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
         4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
         4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
         4'd9: return 7'h6F;  default: return 7'h00;
      endcase
   endfunction

   function automatic logic [6:0] ref_seg(input logic [11:0] b, input int k);
      logic [3:0] h, t, o;
      h = b[11:8]; t = b[7:4]; o = b[3:0];
`ifdef LEADING_ZERO_BLANK_EN
      if (k == 2 && h == 0) return 7'h00;
      if (k == 1 && h == 0 && t == 0) return 7'h00;
`endif
      if (k == 2) return ref_glyph(h);
      if (k == 1) return ref_glyph(t);
      return ref_glyph(o);
   endfunction

   // Reference: accept when idle, result 9 edges later, display lags bcd by one edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy    <= 0;
         m_val     <= 0;
         m_n       <= 0;
         m_bcd     <= '0;
         m_seg_bcd <= '0;
         m_valid   <= 1'b0;
      end else begin
         m_n       <= m_n + 1;
         m_seg_bcd <= m_bcd;
         m_valid   <= 1'b0;
         if (m_busy == 0) begin
            if (in_valid) begin
               m_val  <= int'(count_in);
               m_busy <= 9;
            end
         end else begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
               m_bcd   <= to_bcd(m_val);
               m_valid <= 1'b1;
            end
         end
      end
   end

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin : mon
      int k;
      k = (m_n == 0) ? 0 : ((m_n - 1) / SCAN_DIV) % 3;
      chk("in_ready", 32'(in_ready), 32'(m_busy == 0));
      chk("bcd_out", 32'(bcd_out), 32'(m_bcd));
      chk("bcd_valid", 32'(bcd_valid), 32'(m_valid));
      chk("dig_en", 32'(dig_en), 32'(3'b001 << k));
      chk("seg", 32'(seg), 32'(ref_seg(m_seg_bcd, k)));
   end

   task automatic send(input logic [7:0] v);
      int t;
      t = 0;
      while (m_busy != 0 && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      chk("idle_wait", 32'(t < 20), 32'd1);
      count_in = v;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (!bcd_valid && t < 15) begin
         @(posedge clk); #1;
         t++;
      end
      chk("done_seen", 32'(t < 15), 32'd1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; count_in = '0;
      #2;
      chk("rst_bcd", 32'(bcd_out), 32'h000);
      chk("rst_seg", 32'(seg), 32'h3F);
      chk("rst_dig", 32'(dig_en), 32'b001);
      chk("rst_rdy", 32'(in_ready), 32'd1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (14) @(posedge clk);
      #1;

      // maximum value and exact latency
      send(8'd255);
      for (int i = 0; i < 9; i++) begin
         chk("busy_ready", 32'(in_ready), 32'd0);
         chk("busy_valid", 32'(bcd_valid), 32'd0);
         @(posedge clk); #1;
      end
      chk("max_valid", 32'(bcd_valid), 32'd1);
      chk("max_bcd", 32'(bcd_out), 32'h255);
      chk("max_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      chk("max_pulse", 32'(bcd_valid), 32'd0);

      // request while busy is dropped
      send(8'd10);
      count_in = 8'd128; in_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1 in_valid = 1'b0;
      wait_done();
      chk("drop_bcd", 32'(bcd_out), 32'h010);
      send(8'd128);
      wait_done();
      chk("after_drop", 32'(bcd_out), 32'h128);

      // scan order and leading zeros
      send(8'd123);
      wait_done();
      repeat (30) @(posedge clk);
      #1;
      send(8'd7);
      wait_done();
      repeat (15) @(posedge clk);
      #1;

      // reset in the middle of SHIFT (iter=4)
      send(8'd200);
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #4 rst = 1'b0;
      chk("abort_bcd", 32'(bcd_out), 32'h000);
      chk("abort_valid", 32'(bcd_valid), 32'd0);
      chk("abort_ready", 32'(in_ready), 32'd1);
      chk("abort_dig", 32'(dig_en), 32'b001);
      @(posedge clk); #1;
      send(8'd200);
      wait_done();
      chk("redo_bcd", 32'(bcd_out), 32'h200);

      // in_valid held: back-to-back accepts every 10 clocks
      count_in = 8'd77; in_valid = 1'b1;
      repeat (25) @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1;

      // randomized conversions with noise while busy and random gaps
      for (int r = 0; r < 30; r++) begin
         int v, noise;
         v = int'($urandom_range(255));
         send(8'(v));
         noise = int'($urandom_range(5));
         for (int j = 0; j < noise; j++) begin
            count_in = 8'($urandom);
            in_valid = 1'b1;
            @(posedge clk); #1;
         end
         in_valid = 1'b0;
         wait_done();
         chk("rand_bcd", 32'(bcd_out), 32'(to_bcd(v)));
         repeat ($urandom_range(8)) @(posedge clk);
         #1;
      end

      repeat (5) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
